// File: rtl/gmem_pkg.sv
// Shared encodings for the unified memory-port responder.
package gmem_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

endpackage

// File: rtl/gmem_responder_if.sv
// CPU <-> memory request/response bundle; the CPU is the master.
interface gmem_responder_if;

   logic        mem_r;
   logic        mem_w;
   logic        mem_s;
   logic [1:0]  mem_c;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   modport master (
      output mem_r, mem_w, mem_s, mem_c, addr, wdata,
      input  rdata, ready, err
   );

   modport slave (
      input  mem_r, mem_w, mem_s, mem_c, addr, wdata,
      output rdata, ready, err
   );

endinterface

// File: rtl/gmem_lane_align.sv
// Little-endian lane steering: byte enables, store merge, load extract/extend
// and the size/alignment error flag.
module gmem_lane_align
   import gmem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] wdata,
   input  logic [31:0] ram_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_word,
   output logic [31:0] load_word,
   output logic        misalign
);

   logic [31:0] wdata_rep;
   logic [7:0]  load_byte;
   logic [15:0] load_half;

   // Store data is replicated across lanes so byte_en alone picks the target.
   always_comb begin
      byte_en   = 4'b0000;
      wdata_rep = wdata;
      misalign  = 1'b0;
      case (size)
         SZ_WORD: begin
            byte_en  = 4'b1111;
            misalign = (addr_lo != 2'b00);
         end
         SZ_HALF: begin
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            misalign  = addr_lo[0];
         end
         SZ_BYTE: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         default: misalign = 1'b1;
      endcase
   end

   always_comb begin
      store_word = ram_word;
      for (int i = 0; i < 4; i++) begin
         if (byte_en[i]) store_word[8*i +: 8] = wdata_rep[8*i +: 8];
      end
   end

   assign load_byte = ram_word[{addr_lo, 3'b000} +: 8];
   assign load_half = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];

   always_comb begin
      load_word = ram_word;
      case (size)
         SZ_HALF: load_word = {{16{sign & load_half[15]}}, load_half};
         SZ_BYTE: load_word = {{24{sign & load_byte[7]}}, load_byte};
         default: load_word = ram_word;
      endcase
   end

endmodule

// File: rtl/gmem_responder.sv
// Single-outstanding memory responder: accept, wait WAIT cycles, access the
// word RAM, then pulse ready for one cycle.
module gmem_responder
   import gmem_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 2
) (
   input logic             clk,
   input logic             rst,
   gmem_responder_if.slave bus
);

   state_e            state;
   state_e            state_next;
   logic [CNT_W-1:0]  cnt;
   logic              req_r;
   logic              req_w;
   logic              req_s;
   logic [1:0]        req_c;
   logic [ADDR_W+1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [31:0]       rdata_q;
   logic              ready_q;
   logic              err_q;

   logic [31:0]       ram [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       ram_word;
   logic [31:0]       store_word;
   logic [31:0]       load_word;
   logic [3:0]        byte_en;
   logic              misalign;
   logic              acc_err;
   logic              access;

   assign word_idx = req_addr[ADDR_W+1:2];
   assign ram_word = ram[word_idx];
   assign acc_err  = misalign | (req_r & req_w);
   assign access   = (state == S_BUSY) && (cnt == '0);

   gmem_lane_align u_align (
      .addr_lo    (req_addr[1:0]),
      .size       (req_c),
      .sign       (req_s),
      .wdata      (req_wdata),
      .ram_word   (ram_word),
      .byte_en    (byte_en),
      .store_word (store_word),
      .load_word  (load_word),
      .misalign   (misalign)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.mem_r || bus.mem_w) state_next = S_BUSY;
         S_BUSY:  if (cnt == '0) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ready/err are registered on the access edge so they are high exactly in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         req_r     <= 1'b0;
         req_w     <= 1'b0;
         req_s     <= 1'b0;
         req_c     <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         if (state == S_IDLE && (bus.mem_r || bus.mem_w)) begin
            req_r     <= bus.mem_r;
            req_w     <= bus.mem_w;
            req_s     <= bus.mem_s;
            req_c     <= bus.mem_c;
            req_addr  <= bus.addr[ADDR_W+1:0];
            req_wdata <= bus.wdata;
            cnt       <= CNT_W'(WAIT);
         end else if (state == S_BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else if (access) begin
            ready_q <= 1'b1;
            err_q   <= acc_err;
            if (acc_err)    rdata_q <= '0;
            else if (req_r) rdata_q <= load_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (access && req_w && !acc_err && (byte_en != 4'b0000))
         ram[word_idx] <= store_word;
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_gmem_responder.sv
// Randomized + directed check of gmem_responder against a byte-array model;
// dut_a runs WAIT=2, dut_b runs WAIT=0.
module tb_gmem_responder;
   import gmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   int          sel;
   logic        drv_r, drv_w, drv_s;
   logic [1:0]  drv_c;
   logic [31:0] drv_addr, drv_wdata;
   logic        obs_ready, obs_err;
   logic [31:0] obs_rdata;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  mem_model [2][4096];
   logic [31:0] last_rdata [2];
   logic [31:0] got_rdata;
   logic        got_err;

   always #5 clk = ~clk;

   gmem_responder_if bus_a ();
   gmem_responder_if bus_b ();

   gmem_responder #(.ADDR_W(10), .WAIT(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   gmem_responder #(.ADDR_W(10), .WAIT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   assign bus_a.mem_r = (sel == 0) && drv_r;
   assign bus_a.mem_w = (sel == 0) && drv_w;
   assign bus_b.mem_r = (sel == 1) && drv_r;
   assign bus_b.mem_w = (sel == 1) && drv_w;
   assign bus_a.mem_s = drv_s;
   assign bus_b.mem_s = drv_s;
   assign bus_a.mem_c = drv_c;
   assign bus_b.mem_c = drv_c;
   assign bus_a.addr  = drv_addr;
   assign bus_b.addr  = drv_addr;
   assign bus_a.wdata = drv_wdata;
   assign bus_b.wdata = drv_wdata;

   assign obs_ready = (sel == 0) ? bus_a.ready : bus_b.ready;
   assign obs_err   = (sel == 0) ? bus_a.err   : bus_b.err;
   assign obs_rdata = (sel == 0) ? bus_a.rdata : bus_b.rdata;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit modelErr(bit r, bit w, logic [1:0] c, logic [31:0] a);
      return (c == 2'b11) || (c == SZ_WORD && a[1:0] != 2'b00) || (c == SZ_HALF && a[0]) || (r && w);
   endfunction

   function automatic int sizeBytes(logic [1:0] c);
      return (c == SZ_WORD) ? 4 : (c == SZ_HALF) ? 2 : 1;
   endfunction

   task automatic modelStore(input int s, input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd);
      int base;
      base = int'(a[11:0]);
      for (int i = 0; i < sizeBytes(c); i++) mem_model[s][base + i] = wd[8*i +: 8];
   endtask

   function automatic logic [31:0] modelLoad(int s, logic [1:0] c, bit sg, logic [31:0] a);
      logic [63:0] v;
      int n, base;
      v = 64'd0;
      n = sizeBytes(c);
      base = int'(a[11:0]);
      for (int i = 0; i < n; i++) v = v | (64'(mem_model[s][base + i]) << (8 * i));
      if (sg && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      return v[31:0];
   endfunction

   task automatic waitReady(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!obs_ready && lat < 40);
   endtask

   task automatic applyStimulus(input int s, input bit r, input bit w, input bit sg,
                                input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd);
      int lat;
      bit e;
      logic [31:0] exp_rd;
      e = modelErr(r, w, c, a);
      if (e)      exp_rd = 32'h0;
      else if (r) exp_rd = modelLoad(s, c, sg, a);
      else        exp_rd = last_rdata[s];
      if (w && !e) modelStore(s, c, a, wd);
      last_rdata[s] = exp_rd;

      @(negedge clk);
      sel = s; drv_r = r; drv_w = w; drv_s = sg; drv_c = c; drv_addr = a; drv_wdata = wd;
      @(posedge clk);
      waitReady(lat);
      drv_r = 1'b0;
      drv_w = 1'b0;
      got_rdata = obs_rdata;
      got_err   = obs_err;
      checkOutput("latency", lat, (s == 0) ? 3 : 1);
      checkOutput("err", {31'b0, obs_err}, {31'b0, e});
      checkOutput("rdata", obs_rdata, exp_rd);
      @(posedge clk);
      #1;
      checkOutput("ready_pulse", {31'b0, obs_ready}, 32'h0);
      checkOutput("err_clear", {31'b0, obs_err}, 32'h0);
      checkOutput("rdata_hold", obs_rdata, exp_rd);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat, k;
      bit r, w, sg;
      logic [1:0] c;
      logic [31:0] a;

      rst = 1'b1; sel = 0;
      drv_r = 0; drv_w = 0; drv_s = 0; drv_c = 0; drv_addr = 0; drv_wdata = 0;
      last_rdata[0] = 0; last_rdata[1] = 0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready_a", {31'b0, bus_a.ready}, 32'h0);
      checkOutput("rst_err_a", {31'b0, bus_a.err}, 32'h0);
      checkOutput("rst_rdata_a", bus_a.rdata, 32'h0);
      checkOutput("rst_ready_b", {31'b0, bus_b.ready}, 32'h0);
      checkOutput("rst_rdata_b", bus_b.rdata, 32'h0);
      @(negedge clk) rst = 1'b1;

      applyStimulus(0, 0, 1, 0, SZ_WORD, 32'h40, 32'h12345678);
      checkOutput("tp_wr_err", {31'b0, got_err}, 32'h0);
      applyStimulus(0, 1, 0, 0, SZ_WORD, 32'h40, 32'h0);
      checkOutput("tp_word_rt", got_rdata, 32'h12345678);
      applyStimulus(0, 0, 1, 0, SZ_BYTE, 32'h41, 32'h80);
      applyStimulus(0, 1, 0, 0, SZ_WORD, 32'h40, 32'h0);
      checkOutput("tp_byte_merge", got_rdata, 32'h12348078);
      applyStimulus(0, 1, 0, 1, SZ_BYTE, 32'h41, 32'h0);
      checkOutput("tp_byte_s", got_rdata, 32'hFFFFFF80);
      applyStimulus(0, 1, 0, 0, SZ_BYTE, 32'h41, 32'h0);
      checkOutput("tp_byte_u", got_rdata, 32'h00000080);
      applyStimulus(0, 0, 1, 0, SZ_WORD, 32'h40, 32'h8001ABCD);
      applyStimulus(0, 1, 0, 1, SZ_HALF, 32'h42, 32'h0);
      checkOutput("tp_half_s", got_rdata, 32'hFFFF8001);
      applyStimulus(0, 1, 0, 0, SZ_HALF, 32'h40, 32'h0);
      checkOutput("tp_half_u", got_rdata, 32'h0000ABCD);

      applyStimulus(0, 1, 0, 0, SZ_WORD, 32'h42, 32'h0);
      checkOutput("tp_err_word", {31'b0, got_err}, 32'h1);
      applyStimulus(0, 0, 1, 0, SZ_HALF, 32'h41, 32'hFFFF);
      checkOutput("tp_err_half", {31'b0, got_err}, 32'h1);
      applyStimulus(0, 1, 0, 0, 2'b11, 32'h40, 32'h0);
      checkOutput("tp_err_size", {31'b0, got_err}, 32'h1);
      applyStimulus(0, 1, 1, 0, SZ_WORD, 32'h40, 32'hFFFFFFFF);
      checkOutput("tp_err_rw", {31'b0, got_err}, 32'h1);
      applyStimulus(0, 1, 0, 0, SZ_WORD, 32'h40, 32'h0);
      checkOutput("tp_err_ram", got_rdata, 32'h8001ABCD);

      // Back-to-back on dut_b: write held, then switched to a read while still asserted.
      @(negedge clk);
      sel = 1; drv_r = 0; drv_w = 1; drv_s = 0; drv_c = SZ_WORD; drv_addr = 32'h1004; drv_wdata = 32'hCAFEF00D;
      @(posedge clk);
      waitReady(lat);
      checkOutput("b2b_lat1", lat, 1);
      drv_w = 0; drv_r = 1; drv_addr = 32'h0000_0004;
      waitReady(lat);
      drv_r = 0;
      checkOutput("b2b_lat2", lat, 3);
      checkOutput("b2b_wrap", obs_rdata, 32'hCAFEF00D);
      modelStore(1, SZ_WORD, 32'h1004, 32'hCAFEF00D);
      last_rdata[1] = 32'hCAFEF00D;
      @(posedge clk);
      #1;

      applyStimulus(0, 0, 1, 0, SZ_WORD, 32'h80, 32'h11223344);
      applyStimulus(0, 1, 0, 0, SZ_WORD, 32'h80, 32'h0);
      @(negedge clk);
      sel = 0; drv_r = 0; drv_w = 1; drv_c = SZ_WORD; drv_addr = 32'h80; drv_wdata = 32'hDEADBEEF;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drv_w = 1'b0;
      #1;
      checkOutput("abort_ready", {31'b0, bus_a.ready}, 32'h0);
      checkOutput("abort_err", {31'b0, bus_a.err}, 32'h0);
      checkOutput("abort_rdata", bus_a.rdata, 32'h0);
      last_rdata[0] = 0; last_rdata[1] = 0;
      @(negedge clk) rst = 1'b1;
      applyStimulus(0, 1, 0, 0, SZ_WORD, 32'h80, 32'h0);
      checkOutput("abort_ram", got_rdata, 32'h11223344);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 1, 0, SZ_WORD, i * 4, $urandom);
         applyStimulus(1, 0, 1, 0, SZ_WORD, i * 4, $urandom);
      end
      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 8);
         c = (k < 3) ? SZ_WORD : (k < 6) ? SZ_HALF : (k < 8) ? SZ_BYTE : 2'b11;
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(sizeBytes(c) - 1);
         k = $urandom_range(0, 9);
         r = (k < 5) || (k == 9);
         w = (k >= 5);
         sg = $urandom_range(0, 1) == 1;
         applyStimulus($urandom_range(0, 1), r, w, sg, c, a, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gmem_responder.md
# gmem_responder

Memory-side responder for the multicycle CPU's unified memory port. It accepts one read or write request at a time from the CPU (`Gmem_R`/`Gmem_W`, `GmemAddr`, `dataOut`, `MEM_S`, `MEM_C`) and performs byte, halfword or word accesses with configurable wait states on an internal word-organised RAM. It returns load data, sign- or zero-extended, on the CPU's `dataIn` bus, together with a one-cycle `ready` strobe and an `err` flag. The same port serves both instruction fetch and data access.

## Interface
- `ADDR_W`, default 10: RAM depth is 2^ADDR_W 32-bit words.
- `WAIT`, default 2: extra wait cycles per access, range 0..15.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `mem_r`  in  1: read request; connects to `Gmem_R`.
- `mem_w`  in  1: write request; connects to `Gmem_W`.
- `mem_s`  in  1: load sign-extend enable (1 = signed); connects to `MEM_S`.
- `mem_c`  in  2: access size; 00 = word, 01 = half, 10 = byte, 11 = illegal; connects to `MEM_C`.
- `addr`  in  32: byte address; connects to `GmemAddr`.
- `wdata`  in  32: store data, right-aligned; connects to `dataOut`.
- `rdata`  out  32: load data, right-aligned and extended; connects to `dataIn`.
- `ready`  out  1: one-cycle completion strobe.
- `err`  out  1: error status of the completing access; meaningful only while `ready`=1.

## Operation
- States are IDLE, BUSY and DONE. Reset forces IDLE, `cnt`=0, `rdata`=0, `ready`=0 and `err`=0. RAM contents are not reset.
- **IDLE:** when `mem_r` or `mem_w` is sampled high, latch `mem_r`, `mem_w`, `mem_s`, `mem_c`, `addr` and `wdata`, load `cnt`=WAIT, and go to BUSY. Input changes after acceptance are ignored.
- **BUSY:** if `cnt`≠0, decrement it. If `cnt`=0, perform the access on this edge and go to DONE.
- **DONE:** `ready`=1 for exactly one cycle, then go to IDLE.
- **Word index:** `addr[ADDR_W+1:2]`. Upper address bits are ignored, so the address space wraps modulo 2^(ADDR_W+2) bytes.
- **Lanes:** little-endian. Byte lane k = `addr[1:0]` occupies bits [8k+7:8k]. The half lane is selected by `addr[1]`.
- **Store:**
  - Byte writes `wdata[7:0]` into lane k only.
  - Half writes `wdata[15:0]` into the selected half only.
  - Word writes all 32 bits.
  - Unselected lanes are preserved.
- **Load:** extract the selected byte or half and extend it to 32 bits. When `mem_s`=1 it is sign-extended, otherwise zero-extended. The size field `mem_c` is honoured for reads as well, including instruction fetch, which uses word.
- **Error conditions:** word with `addr[1:0]`≠0; half with `addr[0]`=1; `mem_c`=11; `mem_r` and `mem_w` both high at acceptance.
  - On error: no RAM write, `rdata`=0 in DONE, `err`=1 with `ready`.
- **After an access:** `rdata` keeps its DONE value until the next completed read. A completed write leaves `rdata` unchanged. A completed error access sets `rdata` to 0.
- `err` returns to 0 in the cycle after DONE.

## Timing
- Acceptance edge is T0. `ready` is high during cycle T0+WAIT+2, counted in edges after T0.
  - WAIT=0: `ready` in the second cycle after acceptance.
  - WAIT=2: `ready` in the fourth.
- Write data is in RAM after the edge that enters DONE. A read accepted in the IDLE following DONE returns the new value.
- **Handshake:** the CPU holds its request until it sees `ready`, then drops it in the following cycle, the first IDLE cycle.
  - A request still high in that IDLE cycle is accepted as a new access; back-to-back accesses have no bubble beyond this.
- Requests during BUSY or DONE are ignored and never queued.
- Reset asserted mid-access aborts it at once: no `ready`. A pending write that has not reached its access edge is lost.
- Throughput: one access per WAIT+3 cycles.

## Structure
- Package `gmem_pkg`:
  - `MEM_C` encodings (`SZ_WORD`, `SZ_HALF`, `SZ_BYTE`).
  - State enum (`S_IDLE`, `S_BUSY`, `S_DONE`).
  - `WAIT` counter width (4).
- Sub-module `gmem_lane_align`: combinational. Takes `addr[1:0]`, size, sign, store data and RAM word. Produces the 4-bit byte-enable, the merged store word, the aligned/extended load word, and the misalign flag.
- RAM is a behavioural `reg [31:0]` array inside `gmem_responder`, with a single port and a synchronous write.

## Test plan
- **Word round trip:** WAIT=2; write 0x12345678 to 0x40, then read 0x40 as a word → `ready` at T0+4 each time, `rdata`=0x12345678, `err`=0.
- **Byte store and signed/unsigned loads:** word at 0x40 = 0x12345678; store byte 0x80 to 0x41.
  - Word read → 0x12348078.
  - Signed byte load at 0x41 → 0xFFFFFF80.
  - Unsigned byte load at 0x41 → 0x00000080.
- **Half loads:** word = 0x8001ABCD.
  - Signed half at 0x42 → 0xFFFF8001.
  - Unsigned half at 0x40 → 0x0000ABCD.
- **Errors:** for each case below → `err`=1 with `ready`, `rdata`=0, RAM unchanged.
  - Word read at 0x42.
  - Half write at 0x41.
  - `mem_c`=11.
  - `mem_r`=`mem_w`=1.
- **Wrap, WAIT=0, back-to-back:** ADDR_W=10, WAIT=0; write word 0xCAFEF00D to 0x1004, then read 0x0004 → 0xCAFEF00D. `ready` in the second cycle after each acceptance. A request held into IDLE starts a second access.
- **Reset mid-access:** assert `rst`=0 during BUSY of a write → `ready`, `err` and `rdata` all 0 immediately. Target word unchanged after release. The next request completes normally.
